// File: rtl/mem_bist_ctrl_pkg.sv
// Shared definitions for the memory BIST controller: FSM encoding,
// LFSR tap set, reset/default seeds and the LFSR step function.
package mem_bist_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_WR     = 3'd1,
      ST_RESEED = 3'd2,
      ST_RD     = 3'd3,
      ST_RWAIT  = 3'd4,
      ST_FIN    = 3'd5
   } bist_state_e;

   // Feedback taps on bits 7, 5, 4 and 3.
   localparam logic [7:0] LFSR_TAPS     = 8'hB8;
   localparam logic [7:0] LFSR_RST      = 8'h01;
   localparam logic [7:0] DEF_SEED_DFLT = 8'h01;

   function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
      return {cur[6:0], ^(cur & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/lfsr8_ld.sv
// 8-bit Fibonacci LFSR with synchronous load; load wins over advance.
module lfsr8_ld
   import mem_bist_ctrl_pkg::*;
(
   input  logic       CLK,
   input  logic       RSTN,
   input  logic       LD,
   input  logic [7:0] SEED,
   input  logic       EN,
   output logic [7:0] OUT
);

   logic [7:0] lfsr_d;
   logic [7:0] lfsr_q;

   // Next pattern: load, step or hold
   always_comb begin
      lfsr_d = lfsr_q;
      if (LD) begin
         lfsr_d = SEED;
      end else if (EN) begin
         lfsr_d = lfsr_next(lfsr_q);
      end else begin
         lfsr_d = lfsr_q;
      end
   end

   // Pattern register, active-high synchronous reset
   always_ff @(posedge CLK) begin
      if (RSTN) begin
         lfsr_q <= LFSR_RST;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   assign OUT = lfsr_q;

endmodule

// File: rtl/mem_bist_ctrl.sv
// Memory BIST controller: writes an LFSR pattern over the whole address
// range, replays the same sequence on readback and records mismatches.
module mem_bist_ctrl
   import mem_bist_ctrl_pkg::*;
#(
   parameter int unsigned ADDR_W   = 8,
   parameter logic [7:0]  DEF_SEED = DEF_SEED_DFLT
) (
   input  logic              CLK,
   input  logic              RSTN,
   input  logic              START,
   input  logic [7:0]        SEED_IN,
   output logic              MEM_REQ,
   output logic              MEM_WE,
   output logic [ADDR_W-1:0] MEM_ADDR,
   output logic [7:0]        MEM_WDATA,
   input  logic              MEM_GNT,
   input  logic              MEM_RVALID,
   input  logic [7:0]        MEM_RDATA,
   output logic              BUSY,
   output logic              DONE,
   output logic              FAIL,
   output logic [7:0]        ERR_CNT,
   output logic [ADDR_W-1:0] FAIL_ADDR
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};
   localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

   bist_state_e       state_d, state_q;
   logic [ADDR_W-1:0] addr_d, addr_q;
   logic [7:0]        seed_d, seed_q;
   logic [7:0]        err_cnt_d, err_cnt_q;
   logic              fail_d, fail_q;
   logic [ADDR_W-1:0] fail_addr_d, fail_addr_q;
   logic              lfsr_ld_s;
   logic              lfsr_en_s;
   logic [7:0]        lfsr_seed_s;
   logic [7:0]        lfsr_out_s;

   lfsr8_ld u_lfsr (
      .CLK  (CLK),
      .RSTN (RSTN),
      .LD   (lfsr_ld_s),
      .SEED (lfsr_seed_s),
      .EN   (lfsr_en_s),
      .OUT  (lfsr_out_s)
   );

   // Next-state, address, pattern control and mismatch bookkeeping
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      seed_d      = seed_q;
      err_cnt_d   = err_cnt_q;
      fail_d      = fail_q;
      fail_addr_d = fail_addr_q;
      lfsr_ld_s   = 1'b0;
      lfsr_en_s   = 1'b0;
      lfsr_seed_s = seed_q;
      case (state_q)
         ST_IDLE: begin
            if (START) begin
               seed_d      = (SEED_IN == 8'h00) ? DEF_SEED : SEED_IN;
               lfsr_seed_s = seed_d;
               lfsr_ld_s   = 1'b1;
               addr_d      = {ADDR_W{1'b0}};
               err_cnt_d   = 8'h00;
               fail_d      = 1'b0;
               fail_addr_d = {ADDR_W{1'b0}};
               state_d     = ST_WR;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_WR: begin
            if (MEM_GNT) begin
               lfsr_en_s = 1'b1;
               if (addr_q == LAST_ADDR) begin
                  state_d = ST_RESEED;
               end else begin
                  addr_d = addr_q + ADDR_ONE;
               end
            end else begin
               state_d = ST_WR;
            end
         end
         ST_RESEED: begin
            lfsr_ld_s = 1'b1;
            addr_d    = {ADDR_W{1'b0}};
            state_d   = ST_RD;
         end
         ST_RD: begin
            if (MEM_GNT) begin
               state_d = ST_RWAIT;
            end else begin
               state_d = ST_RD;
            end
         end
         ST_RWAIT: begin
            if (MEM_RVALID) begin
               if (MEM_RDATA != lfsr_out_s) begin
                  err_cnt_d = (err_cnt_q == 8'hFF) ? 8'hFF : err_cnt_q + 8'd1;
                  fail_d    = 1'b1;
                  if (!fail_q) begin
                     fail_addr_d = addr_q;
                  end else begin
                     fail_addr_d = fail_addr_q;
                  end
               end else begin
                  err_cnt_d = err_cnt_q;
               end
               lfsr_en_s = 1'b1;
               if (addr_q == LAST_ADDR) begin
                  state_d = ST_FIN;
               end else begin
                  addr_d  = addr_q + ADDR_ONE;
                  state_d = ST_RD;
               end
            end else begin
               state_d = ST_RWAIT;
            end
         end
         ST_FIN: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Controller registers, active-high synchronous reset
   always_ff @(posedge CLK) begin
      if (RSTN) begin
         state_q     <= ST_IDLE;
         addr_q      <= {ADDR_W{1'b0}};
         seed_q      <= LFSR_RST;
         err_cnt_q   <= 8'h00;
         fail_q      <= 1'b0;
         fail_addr_q <= {ADDR_W{1'b0}};
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         seed_q      <= seed_d;
         err_cnt_q   <= err_cnt_d;
         fail_q      <= fail_d;
         fail_addr_q <= fail_addr_d;
      end
   end

   // Write data is forced to zero outside WR so idle/reset shows 0
   assign MEM_REQ   = (state_q == ST_WR) || (state_q == ST_RD);
   assign MEM_WE    = (state_q == ST_WR);
   assign MEM_ADDR  = addr_q;
   assign MEM_WDATA = (state_q == ST_WR) ? lfsr_out_s : 8'h00;
   assign BUSY      = (state_q != ST_IDLE);
   assign DONE      = (state_q == ST_FIN);
   assign FAIL      = fail_q;
   assign ERR_CNT   = err_cnt_q;
   assign FAIL_ADDR = fail_addr_q;

endmodule

// File: tb/tb_mem_bist_ctrl.sv
// Directed self-checking bench for mem_bist_ctrl with a 4-word memory model
// (grant configurable, read data returned one cycle after the read grant).
module tb_mem_bist_ctrl;

   localparam int unsigned AW = 2;

   logic          CLK = 1'b0;
   logic          RSTN;
   logic          START;
   logic [7:0]    SEED_IN;
   logic          MEM_REQ;
   logic          MEM_WE;
   logic [AW-1:0] MEM_ADDR;
   logic [7:0]    MEM_WDATA;
   logic          MEM_GNT;
   logic          MEM_RVALID;
   logic [7:0]    MEM_RDATA;
   logic          BUSY;
   logic          DONE;
   logic          FAIL;
   logic [7:0]    ERR_CNT;
   logic [AW-1:0] FAIL_ADDR;

   int n_cmp = 0;
   int n_bad = 0;

   logic [7:0] mem [0:3];
   logic [7:0] wr_log_data [0:255];
   int         wr_log_addr [0:255];
   int         wr_cnt      = 0;
   int         corrupt_addr = -1;
   bit         stall_en    = 1'b0;
   int         stall_at    = 0;
   int         stall_cnt   = 0;
   bit         rd_pend     = 1'b0;
   int         rd_addr     = 0;

   mem_bist_ctrl #(.ADDR_W(AW), .DEF_SEED(8'h01)) dut (
      .CLK        (CLK),
      .RSTN       (RSTN),
      .START      (START),
      .SEED_IN    (SEED_IN),
      .MEM_REQ    (MEM_REQ),
      .MEM_WE     (MEM_WE),
      .MEM_ADDR   (MEM_ADDR),
      .MEM_WDATA  (MEM_WDATA),
      .MEM_GNT    (MEM_GNT),
      .MEM_RVALID (MEM_RVALID),
      .MEM_RDATA  (MEM_RDATA),
      .BUSY       (BUSY),
      .DONE       (DONE),
      .FAIL       (FAIL),
      .ERR_CNT    (ERR_CNT),
      .FAIL_ADDR  (FAIL_ADDR)
   );

   always #5 CLK = ~CLK;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // Memory model: acts on the falling edge, away from the DUT's rising edge
   initial begin
      MEM_GNT    = 1'b1;
      MEM_RVALID = 1'b0;
      MEM_RDATA  = 8'h00;
      for (int i = 0; i < 4; i++) mem[i] = 8'h00;
      forever begin
         logic gnt;
         @(negedge CLK);
         MEM_RVALID = rd_pend;
         if (rd_pend) MEM_RDATA = (rd_addr == corrupt_addr) ? 8'h00 : mem[rd_addr];
         else         MEM_RDATA = 8'h00;
         gnt = 1'b1;
         if (stall_en && MEM_REQ && MEM_WE && (wr_cnt == stall_at) && (stall_cnt < 3)) begin
            gnt = 1'b0;
            stall_cnt++;
            check_eq("stall_addr", 32'(MEM_ADDR), 32'd1);
            check_eq("stall_wdata", 32'(MEM_WDATA), 32'h02);
         end
         MEM_GNT = gnt;
         rd_pend = MEM_REQ && gnt && !MEM_WE;
         rd_addr = int'(MEM_ADDR);
         if (MEM_REQ && gnt && MEM_WE) begin
            mem[MEM_ADDR]       = MEM_WDATA;
            wr_log_data[wr_cnt] = MEM_WDATA;
            wr_log_addr[wr_cnt] = int'(MEM_ADDR);
            wr_cnt++;
         end
      end
   end

   task automatic do_start(input logic [7:0] seed);
      START   = 1'b1;
      SEED_IN = seed;
      @(negedge CLK);
      START   = 1'b0;
      SEED_IN = 8'h00;
   endtask

   task automatic wait_done(output int k);
      k = 0;
      while (!DONE && k < 100) begin
         @(negedge CLK);
         k++;
      end
   endtask

   task automatic check_writes(input string tag, input int base, input int n);
      logic [7:0] exp_d;
      exp_d = 8'h01;
      for (int i = 0; i < n; i++) begin
         check_eq({tag, "_wdata"}, 32'(wr_log_data[base + i]), 32'(exp_d));
         check_eq({tag, "_waddr"}, 32'(wr_log_addr[base + i]), 32'(i));
         exp_d = exp_d << 1;
      end
   endtask

   initial begin
      int k;
      int base;
      RSTN    = 1'b1;
      START   = 1'b0;
      SEED_IN = 8'h00;
      repeat (2) @(negedge CLK);
      check_eq("rst_busy", 32'(BUSY), 32'd0);
      check_eq("rst_req", 32'(MEM_REQ), 32'd0);
      check_eq("rst_we", 32'(MEM_WE), 32'd0);
      check_eq("rst_wdata", 32'(MEM_WDATA), 32'h00);
      check_eq("rst_done", 32'(DONE), 32'd0);
      check_eq("rst_errcnt", 32'(ERR_CNT), 32'd0);
      check_eq("rst_fail", 32'(FAIL), 32'd0);

      // START together with reset must be dropped
      START = 1'b1;
      @(negedge CLK);
      START = 1'b0;
      RSTN  = 1'b0;
      @(negedge CLK);
      check_eq("start_in_rst", 32'(BUSY), 32'd0);

      // Ideal memory, seed 0x01
      base = wr_cnt;
      do_start(8'h01);
      check_eq("run1_busy", 32'(BUSY), 32'd1);
      wait_done(k);
      check_eq("run1_latency", 32'(k), 32'd13);
      check_eq("run1_done", 32'(DONE), 32'd1);
      check_eq("run1_nwr", 32'(wr_cnt - base), 32'd4);
      check_writes("run1", base, 4);
      check_eq("run1_fail", 32'(FAIL), 32'd0);
      check_eq("run1_errcnt", 32'(ERR_CNT), 32'd0);
      @(negedge CLK);
      check_eq("run1_done_pulse", 32'(DONE), 32'd0);
      check_eq("run1_idle", 32'(BUSY), 32'd0);

      // Address 2 reads back as zero
      corrupt_addr = 2;
      do_start(8'h01);
      wait_done(k);
      check_eq("run2_latency", 32'(k), 32'd13);
      check_eq("run2_fail", 32'(FAIL), 32'd1);
      check_eq("run2_errcnt", 32'(ERR_CNT), 32'd1);
      check_eq("run2_failaddr", 32'(FAIL_ADDR), 32'd2);
      repeat (3) @(negedge CLK);
      check_eq("run2_hold_fail", 32'(FAIL), 32'd1);
      check_eq("run2_hold_cnt", 32'(ERR_CNT), 32'd1);
      corrupt_addr = -1;

      // Zero seed falls back to the default seed
      base = wr_cnt;
      do_start(8'h00);
      check_eq("seed0_clears_fail", 32'(FAIL), 32'd0);
      wait_done(k);
      check_eq("seed0_wdata0", 32'(wr_log_data[base]), 32'h01);
      check_eq("seed0_wdata1", 32'(wr_log_data[base + 1]), 32'h02);
      check_eq("seed0_fail", 32'(FAIL), 32'd0);
      @(negedge CLK);

      // Grant withheld for 3 cycles on the second write
      base      = wr_cnt;
      stall_at  = wr_cnt + 1;
      stall_cnt = 0;
      stall_en  = 1'b1;
      do_start(8'h01);
      wait_done(k);
      stall_en = 1'b0;
      check_eq("stall_cycles", 32'(stall_cnt), 32'd3);
      check_eq("stall_latency", 32'(k), 32'd16);
      check_writes("stall", base, 4);
      check_eq("stall_fail", 32'(FAIL), 32'd0);
      @(negedge CLK);

      // START while busy is ignored
      base = wr_cnt;
      do_start(8'h01);
      @(negedge CLK);
      START   = 1'b1;
      SEED_IN = 8'h55;
      @(negedge CLK);
      START   = 1'b0;
      SEED_IN = 8'h00;
      wait_done(k);
      check_eq("rebusy_latency", 32'(k + 2), 32'd13);
      check_writes("rebusy", base, 4);
      check_eq("rebusy_fail", 32'(FAIL), 32'd0);
      @(negedge CLK);

      // Reset in the middle of the read phase
      corrupt_addr = 0;
      do_start(8'h01);
      k = 0;
      while (!(MEM_REQ && !MEM_WE && MEM_ADDR == 2'd1) && k < 50) begin
         @(negedge CLK);
         k++;
      end
      check_eq("rstmid_reach_rd", 32'(MEM_REQ && !MEM_WE), 32'd1);
      check_eq("rstmid_pre_err", 32'(ERR_CNT), 32'd1);
      RSTN = 1'b1;
      @(negedge CLK);
      RSTN = 1'b0;
      corrupt_addr = -1;
      check_eq("rstmid_req", 32'(MEM_REQ), 32'd0);
      check_eq("rstmid_busy", 32'(BUSY), 32'd0);
      check_eq("rstmid_errcnt", 32'(ERR_CNT), 32'd0);
      check_eq("rstmid_fail", 32'(FAIL), 32'd0);
      check_eq("rstmid_addr", 32'(MEM_ADDR), 32'd0);
      base = wr_cnt;
      do_start(8'h01);
      wait_done(k);
      check_eq("post_rst_latency", 32'(k), 32'd13);
      check_writes("post_rst", base, 4);
      check_eq("post_rst_fail", 32'(FAIL), 32'd0);
      @(negedge CLK);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule

// File: doc/mem_bist_ctrl.md
MEM_BIST_CTRL -- requirements
Module: mem_bist_ctrl

Interface
REQ-001 Parameter ADDR_W, default 8: memory address width; the test covers addresses 0 .. 2^ADDR_W-1.
REQ-002 Parameter DEF_SEED, default 8'h01: seed used when SEED_IN is zero.
REQ-003 CLK  input  1  sole clock; all logic SHALL be rising-edge triggered.
REQ-004 RSTN  input  1  reset, synchronous and active-high (asserted = 1, despite the name).
REQ-005 START  input  1  one-cycle request to begin a test run.
REQ-006 SEED_IN  input  8  LFSR seed, sampled on the START cycle.
REQ-007 MEM_REQ  output  1  memory access request.
REQ-008 MEM_WE  output  1  1 = write, 0 = read; valid while MEM_REQ=1.
REQ-009 MEM_ADDR  output  ADDR_W  access address.
REQ-010 MEM_WDATA  output  8  write data.
REQ-011 MEM_GNT  input  1  memory accepts the access in this cycle.
REQ-012 MEM_RVALID  input  1  read data valid.
REQ-013 MEM_RDATA  input  8  read data.
REQ-014 BUSY  output  1  a run is in progress.
REQ-015 DONE  output  1  one-cycle pulse at end of run.
REQ-016 FAIL  output  1  the last run saw at least one mismatch.
REQ-017 ERR_CNT  output  8  mismatch count, saturating.
REQ-018 FAIL_ADDR  output  ADDR_W  address of the first mismatch.

Function
REQ-019 Pattern source SHALL be an 8-bit LFSR: next = {cur[6:0], cur[7]^cur[5]^cur[4]^cur[3]}.
REQ-020 FSM states SHALL be IDLE, WR, RESEED, RD, RWAIT, FIN.
REQ-021 IDLE: START=1 -> WR. On that edge: LFSR <= (SEED_IN==0 ? DEF_SEED : SEED_IN), seed latched, addr <= 0, ERR_CNT <= 0, FAIL <= 0, FAIL_ADDR <= 0.
REQ-022 WR: MEM_REQ=1, MEM_WE=1, MEM_WDATA=LFSR, MEM_ADDR=addr.
REQ-023 WR: a transfer occurs on MEM_REQ&MEM_GNT. On transfer, LFSR advances and addr increments; the transfer at the last address goes to RESEED instead of incrementing.
REQ-024 WR: while MEM_GNT=0, MEM_ADDR, MEM_WDATA and MEM_WE SHALL hold stable and the LFSR SHALL NOT advance.
REQ-025 RESEED (one cycle): MEM_REQ=0; LFSR <= latched seed, addr <= 0; -> RD.
REQ-026 RD: MEM_REQ=1, MEM_WE=0; on MEM_GNT -> RWAIT. At most one read is outstanding.
REQ-027 RWAIT: MEM_REQ=0. On MEM_RVALID, MEM_RDATA is compared to the LFSR.
REQ-028 On mismatch: ERR_CNT increments, saturating at 255; FAIL <= 1; FAIL_ADDR captures addr only if this is the first mismatch.
REQ-029 After the RWAIT compare: LFSR advances; if addr was the last address -> FIN, else addr+1 and -> RD.
REQ-030 FIN: DONE=1 for exactly one cycle; -> IDLE.
REQ-031 BUSY=1 in every state except IDLE.
REQ-032 START outside IDLE SHALL be ignored.
REQ-033 MEM_RVALID outside RWAIT SHALL be ignored.
REQ-034 MEM_GNT while MEM_REQ=0 SHALL be ignored.
REQ-035 FAIL, ERR_CNT and FAIL_ADDR SHALL hold their values until the next accepted START.
REQ-036 Address wrap: the last address is 2^ADDR_W-1; the counter SHALL NOT wrap past it within a phase.

Reset
REQ-037 RSTN=1 at a clock edge SHALL force the following, from any state including mid-transfer: state=IDLE, LFSR=8'h01, addr=0, MEM_REQ=0, MEM_WE=0, MEM_WDATA=0, MEM_ADDR=0, BUSY=0, DONE=0, FAIL=0, ERR_CNT=0, FAIL_ADDR=0.
REQ-038 START sampled in the same cycle as RSTN=1 SHALL be ignored.

Structure
REQ-039 A shared package SHALL hold the FSM state encoding, the LFSR tap constant, and the DEF_SEED default.
REQ-040 The LFSR SHALL be a sub-module, lfsr8_ld, with ports CLK, RSTN, LD, SEED, EN, OUT; LD has priority over EN.

Verification
REQ-041 ADDR_W=2, SEED_IN=8'h01, MEM_GNT always 1, MEM_RVALID one cycle after grant, ideal memory -> writes 0x01,0x02,0x04,0x08 to addresses 0..3; DONE pulses 13 cycles after START is sampled; FAIL=0, ERR_CNT=0.
REQ-042 Same setup, memory corrupts address 2 on readback (returns 0x00) -> FAIL=1, ERR_CNT=1, FAIL_ADDR=2.
REQ-043 SEED_IN=8'h00 -> first write data 0x01, second write data 0x02.
REQ-044 MEM_GNT held low for 3 cycles during the write to address 1 -> MEM_ADDR=1 and MEM_WDATA=0x02 stable throughout; the next write carries 0x04.
REQ-045 RSTN pulsed during RD -> next cycle MEM_REQ=0, BUSY=0, ERR_CNT=0; a new START then completes normally.
REQ-046 START re-asserted while BUSY=1 -> no effect on state, addr or pattern.
